ex_hazard_controller: RTL and testbench
=======================================

Name: ex_hazard_controller

Overview:
Pipeline controller for the execution stage of the RV32 pipeline. It issues stall and flush controls to the IF/ID/EX/MEM pipeline registers and operand-forwarding selects to the EX operand muxes. It sequences multi-cycle EX operations with a busy FSM and counter. It also handles load-use interlock and branch/jump redirect flushes.

Parameters:
MC_LATENCY, 4, total cycles a multi-cycle op occupies EX; legal range 2..15.
CNT_W, 4, width of the multi-cycle down-counter.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
RS1AddrD  input  5  rs1 of the instruction in ID
RS2AddrD  input  5  rs2 of the instruction in ID
UsesRs1D  input  1  ID instruction reads rs1
UsesRs2D  input  1  ID instruction reads rs2
RS1AddrE  input  5  rs1 of the instruction in EX
RS2AddrE  input  5  rs2 of the instruction in EX
WriteAddressE  input  5  rd in EX
RegWriteE  input  1  EX instruction writes rd
MemReadE  input  1  EX instruction is a load
MultiCycleE  input  1  EX instruction needs MC_LATENCY cycles
BranchE  input  1  branch taken, from the ALU
JtypeE  input  1  jump in EX
WriteAddressM  input  5  rd in MEM
RegWriteM  input  1  MEM writes rd
WriteAddressW  input  5  rd in WB
RegWriteW  input  1  WB writes rd
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushD  output  1  clear IF/ID to a NOP
FlushE  output  1  clear ID/EX to a NOP
FlushM  output  1  clear EX/MEM to a bubble
ForwardA  output  2  rs1 operand select: 00 regfile, 01 WB, 10 MEM
ForwardB  output  2  rs2 operand select, same encoding
ExBusy  output  1  multi-cycle op in progress
ExDone  output  1  one-cycle pulse on the release cycle of a multi-cycle op

Behaviour:
- Reset: state RUN, counter 0.
- While reset is high, all stall, flush, ExBusy and ExDone outputs are 0. ForwardA and ForwardB remain combinational.
- Reset mid-operation aborts the op: the next cycle is in RUN with all controls 0.
- FSM states are RUN and MCBUSY. The state and counter are registered; all outputs are combinational from the state, the counter and the inputs.
- Forwarding is independent of the FSM:
  - ForwardA=10 if RegWriteM, WriteAddressM≠0 and WriteAddressM==RS1AddrE.
  - Otherwise ForwardA=01 if RegWriteW, WriteAddressW≠0 and WriteAddressW==RS1AddrE.
  - Otherwise ForwardA=00.
  - ForwardB is the same using RS2AddrE. MEM beats WB.
- RUN, evaluated in priority order:
  1. Redirect (BranchE|JtypeE): FlushD=1, FlushE=1, no stalls. Stay in RUN. The load-use check is suppressed because the ID instruction is discarded.
  2. MultiCycleE: StallF=StallD=StallE=1, FlushM=1, ExBusy=1. Next state MCBUSY; counter loads MC_LATENCY-2.
  3. Load-use, when MemReadE, RegWriteE and WriteAddressE≠0, and either (UsesRs1D and RS1AddrD==WriteAddressE) or (UsesRs2D and RS2AddrD==WriteAddressE): StallF=StallD=1, FlushE=1. Exactly one bubble is inserted.
  4. Otherwise all stall and flush outputs are 0.
- MCBUSY:
  - If counter≠0: StallF=StallD=StallE=1, FlushM=1, ExBusy=1; counter decrements.
  - If counter==0 (release): stalls and flushes are 0, ExBusy=0, ExDone=1; next state RUN.
  - BranchE, JtypeE and the load-use check are ignored in MCBUSY; multi-cycle ops are never control-transfer ops.
- Timing: an op occupies EX for exactly MC_LATENCY cycles. Back-to-back multi-cycle ops re-enter MCBUSY on the cycle after release, with no gap beyond the normal RUN cycle.
- Register x0 is never a hazard source and never a forward source.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- When defined, two extra outputs are added: StallCount[31:0] and FlushCount[31:0].
- StallCount increments on every cycle with StallF=1. FlushCount increments on every cycle with FlushD|FlushE=1.
- Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- When the macro is undefined, these ports and counters are absent and there is no other behavioural change.

Test Plan:
- Forward priority: RS1AddrE=5, RegWriteM=1, WriteAddressM=5, RegWriteW=1, WriteAddressW=5 -> ForwardA=10. Change WriteAddressM to 6 -> ForwardA=01. Change RS1AddrE to 0 with matching writes to x0 -> ForwardA=00.
- Load-use: MemReadE=1, RegWriteE=1, WriteAddressE=7, UsesRs2D=1, RS2AddrD=7 -> one cycle with StallF=StallD=FlushE=1. With WriteAddressE=0 -> no stall.
- Multi-cycle, MC_LATENCY=4: MultiCycleE held high -> StallE=1 and ExBusy=1 for 3 cycles, then 1 cycle with ExDone=1 and all stalls 0. Two consecutive ops -> the pattern repeats with no extra bubble.
- Redirect priority: BranchE=1 together with a load-use match -> FlushD=FlushE=1, StallF=0. JtypeE=1 alone -> same flushes.
- Reset mid-op: assert reset on the 2nd MCBUSY cycle -> the next cycle has ExBusy=0 and all stalls 0, and a new MultiCycleE restarts the full 4-cycle sequence.
- With HAZARD_PERF_CNT_EN: one load-use stall followed by one branch -> StallCount=1, FlushCount=2.

Source files
------------

// File: rtl/ex_hazard_controller.sv
// EX-stage hazard controller: forwarding selects, load-use interlock, redirect flushes
// and a RUN/MCBUSY sequencer for multi-cycle ops. HAZARD_PERF_CNT_EN adds stall/flush counters.
module ex_hazard_controller #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RS1AddrD,
  input  logic [4:0] RS2AddrD,
  input  logic       UsesRs1D,
  input  logic       UsesRs2D,
  input  logic [4:0] RS1AddrE,
  input  logic [4:0] RS2AddrE,
  input  logic [4:0] WriteAddressE,
  input  logic       RegWriteE,
  input  logic       MemReadE,
  input  logic       MultiCycleE,
  input  logic       BranchE,
  input  logic       JtypeE,
  input  logic [4:0] WriteAddressM,
  input  logic       RegWriteM,
  input  logic [4:0] WriteAddressW,
  input  logic       RegWriteW,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       ExBusy,
  output logic       ExDone
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic {RUN, MCBUSY} state_t;

  // The RUN cycle that accepts the op counts as one of the MC_LATENCY cycles,
  // and the release cycle is another, hence the load of MC_LATENCY-2.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 2);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             redirect;
  logic             load_use;
  logic [4:0]       rs_e [2];
  logic [1:0]       fwd  [2];

  assign rs_e[0] = RS1AddrE;
  assign rs_e[1] = RS2AddrE;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd[gi] = (RegWriteM && (WriteAddressM != 5'd0) && (WriteAddressM == rs_e[gi])) ? 2'b10 :
                     (RegWriteW && (WriteAddressW != 5'd0) && (WriteAddressW == rs_e[gi])) ? 2'b01 :
                     2'b00;
  end

  assign ForwardA = fwd[0];
  assign ForwardB = fwd[1];

  assign redirect = BranchE | JtypeE;
  assign load_use = MemReadE && RegWriteE && (WriteAddressE != 5'd0) &&
                    ((UsesRs1D && (RS1AddrD == WriteAddressE)) ||
                     (UsesRs2D && (RS2AddrD == WriteAddressE)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (!redirect && MultiCycleE) begin
            state_reg <= MCBUSY;
            cnt_reg   <= CNT_LOAD;
          end
        end
        MCBUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            state_reg <= RUN;
          end
        end
        default: begin
          state_reg <= RUN;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    ExBusy = 1'b0;
    ExDone = 1'b0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          if (redirect) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (MultiCycleE) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            ExBusy = 1'b1;
          end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        MCBUSY: begin
          // Control transfers and load-use cannot originate from a multi-cycle op.
          if (cnt_reg != '0) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            ExBusy = 1'b1;
          end else begin
            ExDone = 1'b1;
          end
        end
        default: begin
          StallF = 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count_reg;
  logic [31:0] flush_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (StallF) stall_count_reg <= stall_count_reg + 32'd1;
      if (FlushD || FlushE) flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign StallCount = stall_count_reg;
  assign FlushCount = flush_count_reg;
`endif

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed bench for ex_hazard_controller: vector table for combinational RUN behaviour,
// hand-written sequences for multi-cycle timing, reset abort and (optionally) perf counters.
module tb_ex_hazard_controller;

  logic       clk;
  logic       reset;
  logic [4:0] RS1AddrD, RS2AddrD, RS1AddrE, RS2AddrE;
  logic       UsesRs1D, UsesRs2D;
  logic [4:0] WriteAddressE, WriteAddressM, WriteAddressW;
  logic       RegWriteE, MemReadE, MultiCycleE, BranchE, JtypeE, RegWriteM, RegWriteW;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, ExBusy, ExDone;
  logic [1:0] ForwardA, ForwardB;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int checks = 0;
  int errors = 0;

  ex_hazard_controller #(.MC_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .RS1AddrD(RS1AddrD), .RS2AddrD(RS2AddrD), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
    .RS1AddrE(RS1AddrE), .RS2AddrE(RS2AddrE), .WriteAddressE(WriteAddressE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MultiCycleE(MultiCycleE),
    .BranchE(BranchE), .JtypeE(JtypeE),
    .WriteAddressM(WriteAddressM), .RegWriteM(RegWriteM),
    .WriteAddressW(WriteAddressW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .ExBusy(ExBusy), .ExDone(ExDone)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1d;
    logic [4:0] rs2d;
    logic       u1;
    logic       u2;
    logic [4:0] rs1e;
    logic [4:0] rs2e;
    logic [4:0] wae;
    logic       rwe;
    logic       mre;
    logic       br;
    logic       jt;
    logic [4:0] wam;
    logic       rwm;
    logic [4:0] waw;
    logic       rww;
    logic [5:0] ctl;   // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,ExBusy,ExDone}
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_BUSY = 8'b1110_0110;
  localparam logic [7:0] C_DONE = 8'b0000_0001;

  logic [7:0] ctl_all;
  assign ctl_all = {StallF, StallD, StallE, FlushD, FlushE, FlushM, ExBusy, ExDone};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic idle_inputs();
    RS1AddrD = 5'd0; RS2AddrD = 5'd0; UsesRs1D = 1'b0; UsesRs2D = 1'b0;
    RS1AddrE = 5'd0; RS2AddrE = 5'd0; WriteAddressE = 5'd0;
    RegWriteE = 1'b0; MemReadE = 1'b0; MultiCycleE = 1'b0; BranchE = 1'b0; JtypeE = 1'b0;
    WriteAddressM = 5'd0; RegWriteM = 1'b0; WriteAddressW = 5'd0; RegWriteW = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    RS1AddrD = v.rs1d; RS2AddrD = v.rs2d; UsesRs1D = v.u1; UsesRs2D = v.u2;
    RS1AddrE = v.rs1e; RS2AddrE = v.rs2e; WriteAddressE = v.wae;
    RegWriteE = v.rwe; MemReadE = v.mre; BranchE = v.br; JtypeE = v.jt; MultiCycleE = 1'b0;
    WriteAddressM = v.wam; RegWriteM = v.rwm; WriteAddressW = v.waw; RegWriteW = v.rww;
  endtask

  task automatic to_drive_point();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] mc_exp [8];

  initial begin
    //               rs1d  rs2d  u1    u2    rs1e  rs2e  wae   rwe   mre   br    jt    wam   rwm   waw   rww   ctl        fa     fb
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 6'b000000, 2'b10, 2'b00};
    vecs[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 6'b000000, 2'b01, 2'b00};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 6'b000000, 2'b00, 2'b00};
    vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 6'b000000, 2'b00, 2'b01};
    vecs[4]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 6'b000000, 2'b10, 2'b10};
    vecs[5]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b110010, 2'b00, 2'b00};
    vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000000, 2'b00, 2'b00};
    vecs[7]  = '{5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000000, 2'b00, 2'b00};
    vecs[8]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b110010, 2'b00, 2'b00};
    vecs[9]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000000, 2'b00, 2'b00};
    vecs[10] = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000110, 2'b00, 2'b00};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000110, 2'b00, 2'b00};
    vecs[12] = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'b000000, 2'b00, 2'b00};
    vecs[13] = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd4, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 6'b110010, 2'b10, 2'b00};

    mc_exp[0] = C_BUSY; mc_exp[1] = C_BUSY; mc_exp[2] = C_BUSY; mc_exp[3] = C_DONE;
    mc_exp[4] = C_BUSY; mc_exp[5] = C_BUSY; mc_exp[6] = C_BUSY; mc_exp[7] = C_DONE;

    // Reset: controls held at 0 even with MultiCycleE/BranchE up; forwarding stays live.
    idle_inputs();
    reset = 1'b1;
    MultiCycleE = 1'b1; BranchE = 1'b1;
    RS1AddrE = 5'd5; WriteAddressM = 5'd5; RegWriteM = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 32'(ctl_all), 32'(C_IDLE));
    chk("reset_fwdA", 32'(ForwardA), 32'd2);

    to_drive_point();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("post_reset_ctl", 32'(ctl_all), 32'(C_IDLE));

    for (int i = 0; i < NVEC; i++) begin
      to_drive_point();
      apply_vec(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM}), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_busydone", i), 32'({ExBusy, ExDone}), 32'd0);
      chk($sformatf("vec%0d_fwdA", i), 32'(ForwardA), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_fwdB", i), 32'(ForwardB), 32'(vecs[i].fb));
    end

    // One load-use bubble: the stalled load advances, a bubble occupies EX, no further stall.
    to_drive_point();
    apply_vec(vecs[5]);
    @(negedge clk);
    chk("lu_bubble_c0", 32'(ctl_all), 32'(8'b1100_1000));
    to_drive_point();
    MemReadE = 1'b0; RegWriteE = 1'b0; WriteAddressE = 5'd0;
    @(negedge clk);
    chk("lu_bubble_c1", 32'(ctl_all), 32'(C_IDLE));

    // Two back-to-back multi-cycle ops; redirect and load-use inputs must be ignored in MCBUSY.
    for (int c = 0; c < 8; c++) begin
      to_drive_point();
      idle_inputs();
      MultiCycleE = 1'b1;
      if (c == 1) BranchE = 1'b1;
      if (c == 2) apply_vec(vecs[5]);
      if (c == 2) MultiCycleE = 1'b1;
      @(negedge clk);
      chk($sformatf("mc_c%0d", c), 32'(ctl_all), 32'(mc_exp[c]));
    end
    to_drive_point();
    idle_inputs();
    @(negedge clk);
    chk("mc_after", 32'(ctl_all), 32'(C_IDLE));

    // Reset on the 2nd MCBUSY cycle aborts the op; a new op runs the full sequence.
    to_drive_point();
    MultiCycleE = 1'b1;
    @(negedge clk);
    chk("rst_op_c0", 32'(ctl_all), 32'(C_BUSY));
    to_drive_point();
    @(negedge clk);
    chk("rst_op_c1", 32'(ctl_all), 32'(C_BUSY));
    to_drive_point();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_op_inreset", 32'(ctl_all), 32'(C_IDLE));
    to_drive_point();
    reset = 1'b0;
    MultiCycleE = 1'b0;
    @(negedge clk);
    chk("rst_op_after", 32'(ctl_all), 32'(C_IDLE));
    for (int c = 0; c < 4; c++) begin
      to_drive_point();
      MultiCycleE = 1'b1;
      @(negedge clk);
      chk($sformatf("rst_restart_c%0d", c), 32'(ctl_all), 32'(mc_exp[c]));
    end
    to_drive_point();
    idle_inputs();
    @(negedge clk);
    chk("rst_restart_after", 32'(ctl_all), 32'(C_IDLE));

`ifdef HAZARD_PERF_CNT_EN
    to_drive_point();
    reset = 1'b1;
    @(negedge clk);
    to_drive_point();
    reset = 1'b0;
    @(negedge clk);
    chk("perf_stall_zero", StallCount, 32'd0);
    chk("perf_flush_zero", FlushCount, 32'd0);
    to_drive_point();
    apply_vec(vecs[5]);
    to_drive_point();
    apply_vec(vecs[11]);
    to_drive_point();
    idle_inputs();
    @(negedge clk);
    chk("perf_stall_count", StallCount, 32'd1);
    chk("perf_flush_count", FlushCount, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
